// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants for the multi-port register file.
//   - default geometry (data width, address width, entry count)
//   - encodings of the clear-sequencer states
package regfile_mp_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DEPTH = 32;

  typedef enum logic [1:0] {
    RF_ST_CLEAR = 2'd0,
    RF_ST_WIPE  = 2'd1,
    RF_ST_READY = 2'd2
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_clear.sv
// regfile_mp_clear: post-reset clear sequencer for regfile_mp.
// Walks every entry once after reset so the array starts from a known value.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; restarts the walk at entry 0
//   clr_we     out  write strobe for the clear value
//   clr_addr   out  entry being cleared this cycle
//   init_busy  out  high while reset is asserted or the walk is in progress
module regfile_mp_clear
  import regfile_mp_pkg::*;
#(
  parameter int AW    = RF_AW,
  parameter int DEPTH = RF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_ST_CLEAR;
      ptr_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic. The first cycle out of reset (still CLEAR) already
  // wipes entry 0, so the whole walk takes exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_ST_CLEAR: begin
        if (ptr_q == PTR_LAST) begin
          state_d = RF_ST_READY;
          ptr_d   = {AW{1'b0}};
        end else begin
          state_d = RF_ST_WIPE;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      RF_ST_WIPE: begin
        if (ptr_q == PTR_LAST) begin
          state_d = RF_ST_READY;
          ptr_d   = {AW{1'b0}};
        end else begin
          state_d = RF_ST_WIPE;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      RF_ST_READY: begin
        state_d = RF_ST_READY;
        ptr_d   = ptr_q;
      end
      default: begin
        state_d = RF_ST_CLEAR;
        ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // Output decode; reset forces busy even from READY.
  always_comb begin
    clr_we    = 1'b0;
    init_busy = 1'b1;
    case (state_q)
      RF_ST_CLEAR, RF_ST_WIPE: begin
        clr_we    = ~rst;
        init_busy = 1'b1;
      end
      RF_ST_READY: begin
        clr_we    = 1'b0;
        init_busy = rst;
      end
      default: begin
        clr_we    = 1'b0;
        init_busy = 1'b1;
      end
    endcase
  end

  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read / 2-write register file with hardware clear after reset.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   raddr [NR*AW]                read addresses, lane i at [i*AW +: AW]
//   rdata [NR*DW]                combinational read data, lane i at [i*DW +: DW]
//   we0/waddr0/wdata0            write port 0
//   we1/waddr1/wdata1            write port 1, wins over port 0 on the same entry
//   init_busy                    high during reset and the clear walk
//   wr_conflict                  one-cycle pulse after both ports hit one entry
// Build option: define REGFILE_MP_BYPASS_EN to forward same-cycle write data
// to matching read lanes (port 1 first).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int             DW         = RF_DW,
  parameter int             AW         = RF_AW,
  parameter int             DEPTH      = RF_DEPTH,
  parameter int             NR         = 2,
  parameter bit             ZERO_REG   = 1'b1,
  parameter logic [DW-1:0]  INIT_VALUE = {DW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [DW-1:0]    wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [DW-1:0]    wdata1,
  output logic             init_busy,
  output logic             wr_conflict
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic          busy_s;
  logic          clr_we_s;
  logic [AW-1:0] clr_addr_s;
  logic          eff0_s, eff1_s;
  logic          conflict_q, conflict_d;
  logic [DW-1:0] mem_q [DEPTH];

  regfile_mp_clear #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
    .init_busy (busy_s)
  );

  // Effective-write qualification: enabled, in range, not the hard-wired zero entry, not busy.
  always_comb begin
    eff0_s = we0 && !busy_s && ({1'b0, waddr0} < DEPTH_W) &&
             !(ZERO_REG && (waddr0 == {AW{1'b0}}));
    eff1_s = we1 && !busy_s && ({1'b0, waddr1} < DEPTH_W) &&
             !(ZERO_REG && (waddr1 == {AW{1'b0}}));
    conflict_d = eff0_s && eff1_s && (waddr0 == waddr1);
  end

  // Array write: the clear walk owns the array while busy; port 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[clr_addr_s] <= INIT_VALUE;
    end else begin
      if (eff0_s) mem_q[waddr0] <= wdata0;
      if (eff1_s) mem_q[waddr1] <= wdata1;
    end
  end

  // Collision flag, one cycle after the colliding writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q && !busy_s;
  assign init_busy   = busy_s;

  // Read lanes: range and zero-entry masks take priority over forwarding and the array.
  always_comb begin
    rdata = {(NR*DW){1'b0}};
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] lane;
      ra   = raddr[i*AW +: AW];
      lane = {DW{1'b0}};
      if (busy_s) begin
        lane = {DW{1'b0}};
      end else if ({1'b0, ra} >= DEPTH_W) begin
        lane = {DW{1'b0}};
      end else if (ZERO_REG && (ra == {AW{1'b0}})) begin
        lane = {DW{1'b0}};
`ifdef REGFILE_MP_BYPASS_EN
      end else if (eff1_s && (waddr1 == ra)) begin
        lane = wdata1;
      end else if (eff0_s && (waddr0 == ra)) begin
        lane = wdata0;
`endif
      end else begin
        lane = mem_q[ra];
      end
      rdata[i*DW +: DW] = lane;
    end
  end

endmodule
